// File: rtl/uart_irq_ctrl.sv
// Interrupt controller for the UART subsystem: pending latch, mask, priority encode, host IRQ.
// Optional coalescing of INT_O is built when UART_IRQ_COALESCE_EN is defined.
module uart_irq_ctrl #(
   parameter  int unsigned NSRC = 8,
   parameter  int unsigned TMRW = 16,
   localparam int unsigned IDW  = $clog2(NSRC)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NSRC-1:0] SRC_I,
   input  logic [NSRC-1:0] EDGE_I,
   input  logic [NSRC-1:0] EN_I,
   input  logic [NSRC-1:0] CLR_I,
   input  logic [7:0]      COAL_CNT_I,
   input  logic [TMRW-1:0] COAL_TMO_I,
   output logic [NSRC-1:0] PEND_O,
   output logic [IDW-1:0]  IID_O,
   output logic            NONE_O,
   output logic            INT_O
);

   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] act;
   logic [IDW-1:0]  iid_q, iid_d;
   logic            none_q, none_d;
   logic            int_q, int_d;

   assign act = pend_q & EN_I;

   // Edge sources: a new rising edge beats a simultaneous clear; level sources follow SRC_I.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (EDGE_I[i])
            pend_d[i] = (SRC_I[i] & ~src_q[i]) | (pend_q[i] & ~CLR_I[i]);
         else
            pend_d[i] = SRC_I[i];
      end
   end

   // Lowest index wins.
   always_comb begin
      iid_d  = '0;
      none_d = 1'b1;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (act[i]) begin
            iid_d  = IDW'(i);
            none_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         src_q  <= '0;
         pend_q <= '0;
         iid_q  <= '0;
         none_q <= 1'b1;
         int_q  <= 1'b0;
      end else begin
         src_q  <= SRC_I;
         pend_q <= pend_d;
         iid_q  <= iid_d;
         none_q <= none_d;
         int_q  <= int_d;
      end
   end

`ifdef UART_IRQ_COALESCE_EN
   typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_e;

   state_e          state_q, state_d;
   logic [7:0]      evt_cnt_q, evt_cnt_d;
   logic [TMRW-1:0] tmr_q, tmr_d;
   logic [NSRC-1:0] act_q;
   logic            act_rise;
   logic [7:0]      cnt_inc;
   logic [TMRW-1:0] tmr_inc;
   logic [TMRW:0]   tmr_p1;
   logic            tmo_hit;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         evt_cnt_q <= '0;
         tmr_q     <= '0;
         act_q     <= '0;
      end else begin
         state_q   <= state_d;
         evt_cnt_q <= evt_cnt_d;
         tmr_q     <= tmr_d;
         act_q     <= act;
      end
   end

   // Coalescing FSM: count new active sources and elapsed cycles until a threshold fires.
   always_comb begin
      state_d   = state_q;
      evt_cnt_d = evt_cnt_q;
      tmr_d     = tmr_q;
      act_rise  = |(act & ~act_q);
      cnt_inc   = (act_rise && (evt_cnt_q != 8'hFF)) ? evt_cnt_q + 8'd1 : evt_cnt_q;
      tmr_inc   = (&tmr_q) ? tmr_q : tmr_q + TMRW'(1);
      tmr_p1    = {1'b0, tmr_q} + (TMRW + 1)'(1);
      tmo_hit   = (COAL_TMO_I != '0) && (tmr_p1 >= {1'b0, COAL_TMO_I});
      case (state_q)
         IDLE: begin
            if (act != '0) begin
               state_d   = ACCUM;
               evt_cnt_d = 8'd1;
               tmr_d     = '0;
            end
         end
         ACCUM: begin
            if (act == '0) begin
               state_d   = IDLE;
               evt_cnt_d = '0;
               tmr_d     = '0;
            end else begin
               evt_cnt_d = cnt_inc;
               tmr_d     = tmr_inc;
               if ((cnt_inc >= COAL_CNT_I) || tmo_hit)
                  state_d = FIRE;
            end
         end
         FIRE: begin
            if (act == '0) begin
               state_d   = IDLE;
               evt_cnt_d = '0;
               tmr_d     = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      int_d = (state_d == FIRE);
   end
`else
   logic unused_coal;
   assign unused_coal = ^{COAL_CNT_I, COAL_TMO_I};

   always_comb begin
      int_d = ~none_d;
   end
`endif

   assign PEND_O = pend_q;
   assign IID_O  = iid_q;
   assign NONE_O = none_q;
   assign INT_O  = int_q;

endmodule
